// File: rtl/sa_pkg.sv
// Shared types for the proc_ele systolic array and its feeders/drains.
// Default geometry: 4-bit operands, 4 columns.
package sa_pkg;

  localparam int unsigned SA_WIDTH = 4;
  localparam int unsigned SA_COLS  = 4;
  localparam int unsigned CW       = 2 * SA_WIDTH + 1;

  typedef logic [CW-1:0]          lane_t;
  typedef lane_t [SA_COLS-1:0]    row_t;

  // Result lane width for a given operand width (product plus accumulate carry).
  function automatic int unsigned lane_width(input int unsigned width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// Synchronous row FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module sa_row_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 36
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DW-1:0]                wdata,
  input  logic                         pop,
  output logic [DW-1:0]                rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sa_drain.sv
// Bottom-row receiver: deskews per-column results, assembles rows and queues them
// toward the result writer; lost rows and ragged skew raise sticky flags.
module sa_drain
  import sa_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [COLS-1:0][2*WIDTH:0]        cin,
  input  logic [COLS-1:0]                   cin_val,
  output logic [COLS-1:0][2*WIDTH:0]        row_data,
  output logic                              row_val,
  input  logic                              row_rdy,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic                              ovf,
  output logic                              skew_err,
  input  logic                              clr_err
);

  localparam int unsigned LCW = lane_width(WIDTH);
  localparam int unsigned RW  = COLS * LCW;

  logic [COLS-1:0][LCW-1:0] al_data;
  logic [COLS-1:0]          al_val;

  // Column j sits COLS-j registers deep so all lanes of a row line up together.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int unsigned N = COLS - j;
    logic [N-1:0][LCW-1:0] d_q;
    logic [N-1:0]          v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= cin[j];
        v_q[0] <= cin_val[j];
        for (int k = 1; k < N; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign al_data[j] = d_q[N-1];
    assign al_val[j]  = v_q[N-1];
  end

  logic          push, pop, full, empty;
  logic          ovf_evt, skew_evt;
  logic          ovf_d, ovf_q, skew_d, skew_q;
  logic [RW-1:0] wdata, rdata;

  assign push     = &al_val;
  assign skew_evt = (|al_val) && !(&al_val);
  assign row_val  = !empty;
  assign pop      = row_val && row_rdy;
  assign ovf_evt  = push && full && !pop;
  assign wdata    = al_data;
  assign row_data = rdata;

  sa_row_fifo #(
    .DEPTH (DEPTH),
    .DW    (RW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Setting an error wins over clearing it in the same cycle.
  always_comb begin
    ovf_d  = ovf_q;
    skew_d = skew_q;
    if (clr_err) begin
      ovf_d  = 1'b0;
      skew_d = 1'b0;
    end
    if (ovf_evt)  ovf_d  = 1'b1;
    if (skew_evt) skew_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      skew_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      skew_q <= skew_d;
    end
  end

  assign ovf      = ovf_q;
  assign skew_err = skew_q;

endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain: skewed row stimulus from a schedule, scoreboard of
// expected rows and arrival cycles, plus direct status checks.
module tb_sa_drain;
  import sa_pkg::*;

  logic       clk, rst_n;
  row_t       cin, row_data;
  logic [3:0] cin_val;
  logic       row_val, row_rdy, ovf, skew_err, clr_err;
  logic [2:0] level;

  sa_drain #(
    .WIDTH (4),
    .COLS  (4),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cin      (cin),
    .cin_val  (cin_val),
    .row_data (row_data),
    .row_val  (row_val),
    .row_rdy  (row_rdy),
    .level    (level),
    .ovf      (ovf),
    .skew_err (skew_err),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    row_t data;
    int   cyc;
  } exp_t;

  exp_t       exp_q[$];
  row_t       sd[int];
  logic [3:0] sv[int];
  int         cyc;
  int         vectors = 0;
  int         errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
    end
  endtask

  function automatic row_t mk(input int a3, input int a2, input int a1, input int a0);
    row_t r;
    r[3] = lane_t'(a3);
    r[2] = lane_t'(a2);
    r[1] = lane_t'(a1);
    r[0] = lane_t'(a0);
    return r;
  endfunction

  task automatic put(input int c, input int col, input lane_t v);
    row_t       t;
    logic [3:0] m;
    t = sd.exists(c) ? sd[c] : '0;
    m = sv.exists(c) ? sv[c] : '0;
    t[col] = v;
    m[col] = 1'b1;
    sd[c] = t;
    sv[c] = m;
  endtask

  // Column j of a row starting at cycle s is driven in cycle s+j.
  task automatic sched_row(input int s, input row_t r, input logic [3:0] mask);
    for (int j = 0; j < 4; j++) if (mask[j]) put(s + j, j, r[j]);
  endtask

  task automatic expect_row(input row_t r, input int c);
    exp_t e;
    e.data = r;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic at(input int n);
    wait (cyc >= n);
    #1;
  endtask

  task automatic sample(input int n);
    at(n);
    @(negedge clk);
  endtask

  // Driver: inputs for cycle n are applied just after the posedge that starts it.
  initial begin
    cyc     = 0;
    cin     = '0;
    cin_val = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sd.exists(cyc)) begin
        cin     = sd[cyc];
        cin_val = sv[cyc];
      end else begin
        cin     = '0;
        cin_val = '0;
      end
    end
  end

  // Monitor: every accepted row is checked against the scoreboard head.
  always @(negedge clk) begin
    if (row_val && row_rdy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_row @cycle %0d: got %0h, expected no row", cyc, row_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("row_data", 64'(row_data), 64'(e.data));
        chk("row_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s, s2;
    row_t r;
    rst_n   = 1'b0;
    row_rdy = 1'b0;
    clr_err = 1'b0;
    #12;
    chk("rst_row_val", 64'(row_val), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_row_data", 64'(row_data), 64'd0);
    chk("rst_flags", 64'({ovf, skew_err}), 64'd0);
    at(3);
    rst_n = 1'b1;

    // Single row
    at(5);
    s = cyc + 2;
    sched_row(s, mk(13, 12, 11, 10), 4'hF);
    sample(s + 4);
    chk("t1_early_val", 64'(row_val), 64'd0);
    sample(s + 5);
    chk("t1_row_val", 64'(row_val), 64'd1);
    chk("t1_row_data", 64'(row_data), 64'(mk(13, 12, 11, 10)));
    chk("t1_level", 64'(level), 64'd1);
    expect_row(mk(13, 12, 11, 10), s + 6);
    at(s + 6);
    row_rdy = 1'b1;
    sample(s + 7);
    chk("t1_level_after", 64'(level), 64'd0);

    // Burst of 8 rows
    at(s + 9);
    s = cyc + 2;
    for (int k = 0; k < 8; k++) begin
      r = mk(16 * k + 3, 16 * k + 2, 16 * k + 1, 16 * k);
      sched_row(s + k, r, 4'hF);
      expect_row(r, s + k + 5);
    end
    for (int c = s; c < s + 15; c++) begin
      sample(c);
      chk("t2_level_le1", 64'(level <= 3'd1), 64'd1);
    end
    chk("t2_flags", 64'({ovf, skew_err}), 64'd0);

    // Overflow
    at(s + 16);
    row_rdy = 1'b0;
    s = cyc + 2;
    for (int k = 0; k < 5; k++)
      sched_row(s + k, mk(32 * k + 4, 32 * k + 3, 32 * k + 2, 32 * k + 1), 4'hF);
    sample(s + 10);
    chk("t3_level_full", 64'(level), 64'd4);
    chk("t3_ovf", 64'(ovf), 64'd1);
    at(s + 11);
    clr_err = 1'b1;
    at(s + 12);
    clr_err = 1'b0;
    #3;
    chk("t3_ovf_clr", 64'(ovf), 64'd0);
    s2 = cyc + 2;
    for (int k = 0; k < 4; k++)
      expect_row(mk(32 * k + 4, 32 * k + 3, 32 * k + 2, 32 * k + 1), s2 + 4 + k);
    sched_row(s2, mk(200, 201, 202, 203), 4'hF);
    expect_row(mk(200, 201, 202, 203), s2 + 8);
    at(s2 + 4);
    row_rdy = 1'b1;
    sample(s2 + 5);
    chk("t3_level_pushpop", 64'(level), 64'd4);
    chk("t3_ovf_pushpop", 64'(ovf), 64'd0);
    sample(s2 + 9);
    chk("t3_level_drained", 64'(level), 64'd0);

    // Skew error
    at(s2 + 10);
    s = cyc + 2;
    for (int k = 0; k < 3; k++) begin
      r = mk(64 + 32 * k + 3, 64 + 32 * k + 2, 64 + 32 * k + 1, 64 + 32 * k);
      sched_row(s + k, r, (k == 1) ? 4'b1011 : 4'hF);
      if (k != 1) expect_row(r, s + k + 5);
    end
    sample(s + 5);
    chk("t4_skew_early", 64'(skew_err), 64'd0);
    sample(s + 8);
    chk("t4_skew_err", 64'(skew_err), 64'd1);
    chk("t4_ovf", 64'(ovf), 64'd0);
    chk("t4_level", 64'(level), 64'd0);
    at(s + 9);
    clr_err = 1'b1;
    at(s + 10);
    clr_err = 1'b0;
    #3;
    chk("t4_skew_clr", 64'(skew_err), 64'd0);

    // Reset mid-row with two rows queued
    at(s + 12);
    row_rdy = 1'b0;
    s = cyc + 2;
    sched_row(s, mk(7, 6, 5, 4), 4'hF);
    sched_row(s + 1, mk(17, 16, 15, 14), 4'hF);
    sched_row(s + 4, mk(27, 26, 25, 24), 4'b0011);
    at(s + 6);
    chk("t5_level_before", 64'(level), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_row_val", 64'(row_val), 64'd0);
    chk("t5_rst_level", 64'(level), 64'd0);
    chk("t5_rst_row_data", 64'(row_data), 64'd0);
    chk("t5_rst_flags", 64'({ovf, skew_err}), 64'd0);
    at(s + 8);
    rst_n   = 1'b1;
    row_rdy = 1'b1;
    s2 = cyc + 2;
    sched_row(s2, mk(300, 301, 302, 303), 4'hF);
    expect_row(mk(300, 301, 302, 303), s2 + 5);
    sample(s2 + 7);
    chk("t5_level_after", 64'(level), 64'd0);
    chk("t5_flags_after", 64'({ovf, skew_err}), 64'd0);

    sample(s2 + 10);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sa_drain.md
# sa_drain

Output-side receiver for the systolic array built from `proc_ele` tiles. It captures the `cout`/`cout_val` streams leaving the bottom row of the array. The bottom row is column-skewed, so column j is valid one cycle after column j-1. The block removes that skew and reassembles each result row. Complete rows are buffered in a small FIFO and presented on a valid/ready port toward the result writer. The array cannot stall, so lost rows and malformed skew are flagged rather than back-pressured.

## Interface
- `WIDTH`, 4, operand width of the PE; result lane width is CW = 2*WIDTH+1.
- `COLS`, 4, number of array columns (≥1).
- `DEPTH`, 4, row FIFO depth (≥2).
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cin`  in  COLS×CW  per-column bottom-row `cout`.
- `cin_val`  in  COLS  per-column bottom-row `cout_val`.
- `row_data`  out  COLS×CW  aligned result row, lane j = column j.
- `row_val`  out  1  row available.
- `row_rdy`  in  1  consumer accepts row.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- `ovf`  out  1  sticky: a complete row was dropped because the FIFO was full.
- `skew_err`  out  1  sticky: aligned valids disagreed.
- `clr_err`  in  1  synchronous clear of `ovf` and `skew_err`.

## Operation
- **Deskew.**
  - Column j passes through a delay line of COLS-j registers; `cin` and `cin_val` are delayed together.
  - Column COLS-1 therefore gets 1 register, and column 0 gets COLS registers.
  - A value on column 0 at cycle t lines up with column j at cycle t+j.
- **Row assembly.** Evaluated on the aligned outputs each cycle:
  - All aligned valids = 1: push the aligned data as one row.
  - All = 0: do nothing.
  - Mixed: no push, and `skew_err` is set.
- **FIFO.**
  - Push is accepted when `level` < DEPTH, or when `level` = DEPTH and a pop happens in the same cycle.
  - Otherwise the row is discarded and `ovf` is set.
  - Pop occurs on `row_val && row_rdy`.
  - `row_val` = (`level` ≠ 0).
  - `row_data` is the head entry; it is stable while `row_val && !row_rdy`.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves `level` unchanged.
- **Data.** Lanes are passed unmodified at CW bits. There is no arithmetic, truncation or sign handling.
- **Sticky flags.**
  - Set has priority over `clr_err` in the same cycle.
  - Flags do not affect data flow.
- **Reset.** Asynchronous assertion clears immediately:
  - delay lines (data and valid) to 0;
  - FIFO pointers;
  - `level` = 0, `row_val` = 0, `row_data` = 0, `ovf` = 0, `skew_err` = 0.
  
  Any partially skewed row in flight is lost. The first row after deassertion is assembled normally.

## Timing
- **Latency.** Column COLS-1 valid in cycle t gives `row_val` = 1 in cycle t+2, provided the FIFO was empty. Column 0 of the same row entered at t-(COLS-1).
- **Throughput.** One row per cycle sustained when `row_rdy` = 1.
- **Status update.** `level`, `ovf` and `skew_err` are registered and update the cycle after the event.
- **Consumer timing.** The `row_rdy` to `row_val` path is combinational only through `level`; there is no combinational path from `cin` to any output.

## Structure
- **Shared package `sa_pkg`.**
  - Lane-width localparam CW = 2*WIDTH+1.
  - Typedef for one result lane.
  - Typedef for the packed row array.
  
  `proc_ele`-based arrays and their feeders reuse the same package.
- **Sub-module `sa_row_fifo`.**
  - Synchronous FIFO, parameters DEPTH and the row width.
  - Ports: push, pop, full, empty, level.
  - Reset is asynchronous, active-low.
- **Deskew delay lines.** Generated inline, one per column.

## Test plan
All scenarios use COLS=4, WIDTH=4 (CW=9), DEPTH=4.
1. **Single row.** Drive column j with value 10+j and valid in cycle 5+j. Required: `row_val` = 1 at cycle 10 with {13,12,11,10}, `level` = 1; popped with `row_rdy` = 1.
2. **Burst.** Stream 8 back-to-back skewed rows (row k lane j = 16k+j) with `row_rdy` = 1. Required: 8 rows, in order, on consecutive cycles, `level` ≤ 1, no flags.
3. **Overflow.** `row_rdy` = 0; 5 rows. Required: `level` = 4, `ovf` = 1, 5th row lost. With `row_rdy` = 1, rows 0–3 drain unchanged; full plus push-and-pop in the same cycle does not set `ovf`.
4. **Skew error.** Drop column 2's valid for one row. Required: that row is not pushed, `skew_err` = 1, neighbouring rows intact. `clr_err` clears it the next cycle.
5. **Reset mid-row.** Assert `rst_n` = 0 after columns 0–1 of a row and with 2 rows queued. Required: all outputs 0 immediately. After release, the next full row emerges alone with correct data.
